usart_echo_tester: RTL and testbench

//  Host-side end of the serial echo link: sends an incrementing 8N1 byte pattern on tx_pin,

---
 rtl/usart_pkg.sv | 28 ++
 rtl/usart_tester_rx.sv | 87 ++++++++
 rtl/usart_echo_tester.sv | 185 ++++++++++++++++++
 tb/tb_usart_echo_tester.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared definitions for the serial echo tester: frame constants, FSM state
// encodings and a saturating counter helper.
package usart_pkg;

    localparam logic     START_BIT    = 1'b0;
    localparam logic     STOP_BIT     = 1'b1;
    localparam int       DATA_BITS    = 8;
    localparam logic [7:0] PATTERN_WRAP = 8'h7F;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/usart_tester_rx.sv
// Receive half of the echo tester: synchronises rx_pin, finds 8N1 frames and
// reports each one when its stop bit is sampled.
//   serial_clock  clock
//   reset         synchronous, active-low
//   cpb_eff       bit period in clocks (already clamped to >= 2)
//   rx_pin        asynchronous serial input, idle high
//   rx_byte       data byte of the last frame
//   frame_done    one-cycle pulse after a stop-bit sample
//   stop_ok       stop bit of the last frame was high
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit; line high there means glitch
// RX_DATA  | sampling 8 data bits at bit centre, LSB first
// RX_STOP  | sampling stop bit at bit centre, then back to idle
module usart_tester_rx
    import usart_pkg::*;
(
    input  logic        serial_clock,
    input  logic        reset,
    input  logic [11:0] cpb_eff,
    input  logic        rx_pin,
    output logic [7:0]  rx_byte,
    output logic        frame_done,
    output logic        stop_ok
);

    rx_state_t   rx_state, rx_next;
    logic        rx_meta, rx_s, rx_prev;
    logic [11:0] rx_timer;
    logic [2:0]  rx_bit_cnt;
    logic [7:0]  rx_shift;
    logic        bit_end;

    assign bit_end = (rx_timer == 12'd0);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (bit_end) rx_next = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
            RX_DATA:  if (bit_end && rx_bit_cnt == 3'(DATA_BITS - 1)) rx_next = RX_STOP;
            RX_STOP:  if (bit_end) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_timer   <= 12'd0;
            rx_bit_cnt <= 3'd0;
            rx_shift   <= 8'd0;
            rx_byte    <= 8'd0;
            frame_done <= 1'b0;
            stop_ok    <= 1'b0;
        end else begin
            rx_meta    <= rx_pin;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            rx_state   <= rx_next;
            frame_done <= 1'b0;
            if (rx_state == RX_IDLE) begin
                // preload half a bit so the start bit is re-checked at its centre
                rx_timer   <= (cpb_eff >> 1) - 12'd1;
                rx_bit_cnt <= 3'd0;
            end else if (bit_end) begin
                rx_timer <= cpb_eff - 12'd1;
                if (rx_state == RX_DATA) begin
                    rx_shift   <= {rx_s, rx_shift[7:1]};
                    rx_bit_cnt <= rx_bit_cnt + 3'd1;
                end
                if (rx_state == RX_STOP) begin
                    frame_done <= 1'b1;
                    stop_ok    <= (rx_s == STOP_BIT);
                    rx_byte    <= rx_shift;
                end
            end else begin
                rx_timer <= rx_timer - 12'd1;
            end
        end
    end

endmodule

// File: rtl/usart_echo_tester.sv
// Host end of the serial echo link: transmits an incrementing 8N1 pattern,
// queues every byte sent and checks each echoed byte against the queue head.
//   serial_clock, reset (sync, active-low), clocks_per_bit (0/1 act as 2)
//   enable, cts_pin        traffic gating
//   rx_pin / tx_pin        serial lines, idle high
//   bytes_sent, bytes_matched, error_count   saturating counters
//   last_expected, last_received             bytes of the latest echo error
//   framing_error, timeout                   sticky flags
//   busy                                     tx in flight or echoes outstanding
//
// state    | meaning
// TX_IDLE  | line high; launches when enabled, cts high and queue not full
// TX_START | start bit
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit
module usart_echo_tester
    import usart_pkg::*;
#(
    parameter logic [7:0] PATTERN_START   = 8'h00,
    parameter int         MAX_OUTSTANDING = 4,
    parameter int         TIMEOUT_FRAMES  = 4
) (
    input  logic        serial_clock,
    input  logic        reset,
    input  logic [11:0] clocks_per_bit,
    input  logic        enable,
    input  logic        cts_pin,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic [15:0] bytes_sent,
    output logic [15:0] bytes_matched,
    output logic [15:0] error_count,
    output logic [7:0]  last_expected,
    output logic [7:0]  last_received,
    output logic        framing_error,
    output logic        timeout,
    output logic        busy
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    tx_state_t   tx_state, tx_next;
    logic [11:0] cpb_eff, tx_timer;
    logic [2:0]  tx_bit_cnt;
    logic [7:0]  tx_shift, next_byte;
    logic        launch, tx_bit_end;

    logic [7:0]       q_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic             q_empty, q_full, pop;

    logic [7:0]  rx_byte, q_head;
    logic        frame_done, stop_ok, echo_bad, to_fire;
    logic [23:0] to_timer, to_limit;

    assign cpb_eff    = (clocks_per_bit < 12'd2) ? 12'd2 : clocks_per_bit;
    assign tx_bit_end = (tx_timer == 12'd0);
    assign to_limit   = 24'(TIMEOUT_FRAMES * 10) * {12'd0, cpb_eff};

    usart_tester_rx u_rx (
        .serial_clock (serial_clock),
        .reset        (reset),
        .cpb_eff      (cpb_eff),
        .rx_pin       (rx_pin),
        .rx_byte      (rx_byte),
        .frame_done   (frame_done),
        .stop_ok      (stop_ok)
    );

    always_comb begin
        tx_next = tx_state;
        launch  = 1'b0;
        case (tx_state)
            TX_IDLE: if (enable && cts_pin && !q_full) begin
                tx_next = TX_START;
                launch  = 1'b1;
            end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_cnt == 3'(DATA_BITS - 1)) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state)
            TX_START: tx_pin = START_BIT;
            TX_DATA:  tx_pin = tx_shift[0];
            default:  tx_pin = STOP_BIT;
        endcase
    end

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            tx_timer   <= 12'd0;
            tx_bit_cnt <= 3'd0;
            tx_shift   <= 8'd0;
            next_byte  <= PATTERN_START;
        end else begin
            tx_state <= tx_next;
            if (launch) begin
                tx_timer   <= cpb_eff - 12'd1;
                tx_bit_cnt <= 3'd0;
                tx_shift   <= next_byte;
                next_byte  <= (next_byte == PATTERN_WRAP) ? 8'h00 : next_byte + 8'd1;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    // reload here so a new clocks_per_bit lands on a bit boundary
                    tx_timer <= cpb_eff - 12'd1;
                    if (tx_state == TX_DATA) begin
                        tx_shift   <= {1'b1, tx_shift[7:1]};
                        tx_bit_cnt <= tx_bit_cnt + 3'd1;
                    end
                end else begin
                    tx_timer <= tx_timer - 12'd1;
                end
            end
        end
    end

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == CNT_W'(MAX_OUTSTANDING));
    assign q_head  = q_mem[rd_ptr];
    assign pop     = frame_done && !q_empty;
    assign echo_bad = frame_done && (q_empty || !stop_ok || rx_byte != q_head);
    // never fires on a stop-sample cycle, so it cannot collide with echo_bad
    assign to_fire = !q_empty && !frame_done && (to_timer == 24'd0);

    always_ff @(posedge serial_clock) begin
        if (launch) q_mem[wr_ptr] <= next_byte;
    end

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (launch) wr_ptr <= wr_ptr + 1'b1;
            if (to_fire) begin
                // flush keeps a byte pushed in the same cycle
                rd_ptr  <= wr_ptr;
                q_count <= launch ? CNT_W'(1) : '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({launch, pop})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    always_ff @(posedge serial_clock) begin
        if (!reset) begin
            bytes_sent    <= 16'd0;
            bytes_matched <= 16'd0;
            error_count   <= 16'd0;
            last_expected <= 8'd0;
            last_received <= 8'd0;
            framing_error <= 1'b0;
            timeout       <= 1'b0;
            to_timer      <= 24'd0;
        end else begin
            if (launch) bytes_sent <= sat_inc(bytes_sent);
            if (frame_done && !echo_bad) bytes_matched <= sat_inc(bytes_matched);
            if (echo_bad || to_fire) error_count <= sat_inc(error_count);
            if (echo_bad) begin
                last_expected <= q_empty ? 8'd0 : q_head;
                last_received <= rx_byte;
            end
            if (frame_done && !q_empty && !stop_ok) framing_error <= 1'b1;
            if (to_fire) timeout <= 1'b1;
            if (q_empty || frame_done || to_fire) to_timer <= to_limit - 24'd1;
            else                                  to_timer <= to_timer - 24'd1;
        end
    end

    assign busy = (tx_state != TX_IDLE) || !q_empty;

endmodule

// File: tb/tb_usart_echo_tester.sv
// Directed bench for usart_echo_tester. A line model at the negative edge
// loops tx_pin back to rx_pin, optionally corrupting one chosen frame, and
// decodes tx_pin to check the transmitted pattern.
module tb_usart_echo_tester;

    logic        serial_clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] cpb = 12'd16;
    logic        enable = 1'b0;
    logic        cts_pin = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic [15:0] bytes_sent, bytes_matched, error_count;
    logic [7:0]  last_expected, last_received;
    logic        framing_error, timeout, busy;

    usart_echo_tester dut (
        .serial_clock   (serial_clock),
        .reset          (reset),
        .clocks_per_bit (cpb),
        .enable         (enable),
        .cts_pin        (cts_pin),
        .rx_pin         (rx_pin),
        .tx_pin         (tx_pin),
        .bytes_sent     (bytes_sent),
        .bytes_matched  (bytes_matched),
        .error_count    (error_count),
        .last_expected  (last_expected),
        .last_received  (last_received),
        .framing_error  (framing_error),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 serial_clock = ~serial_clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // line model state
    logic       loop_en = 1'b1;
    logic       rx_force = 1'b1;
    logic       pat_chk = 1'b0;
    int         flip_frame = 0;
    int         stop_low_frame = 0;
    logic       m_in_frame = 1'b0;
    logic       tx_prev = 1'b1;
    int         m_cyc = 0;
    int         m_frame = 0;
    int         m_zero = 0;
    int         m_bi;
    logic [7:0] m_pat = 8'h00;
    logic [7:0] m_shift = 8'h00;
    logic       m_v;

    always @(negedge serial_clock) begin
        if (!reset) begin
            m_in_frame = 1'b0;
            m_cyc      = 0;
            m_frame    = 0;
            m_zero     = 0;
            m_pat      = 8'h00;
            tx_prev    = 1'b1;
        end else begin
            if (!m_in_frame && tx_prev && !tx_pin) begin
                m_in_frame = 1'b1;
                m_cyc      = 0;
                m_frame++;
            end else if (m_in_frame) begin
                m_cyc++;
                if (m_cyc >= 10 * int'(cpb)) m_in_frame = 1'b0;
            end
            tx_prev = tx_pin;
            if (m_in_frame && pat_chk && (m_cyc % int'(cpb)) == int'(cpb) / 2) begin
                m_bi = m_cyc / int'(cpb);
                if (m_bi >= 1 && m_bi <= 8) m_shift = {tx_pin, m_shift[7:1]};
                else if (m_bi == 9) begin
                    check_eq("tx_stop_bit", tx_pin, 1);
                    check_eq("tx_pattern", m_shift, m_pat);
                    if (m_shift == 8'h00) m_zero++;
                    m_pat = (m_pat == 8'h7F) ? 8'h00 : m_pat + 8'd1;
                end
            end
        end
        m_bi = m_cyc / int'(cpb);
        m_v  = tx_pin;
        if (m_in_frame && m_frame == flip_frame && m_bi == 4) m_v = ~m_v;
        if (m_in_frame && m_frame == stop_low_frame && m_bi == 9) m_v = 1'b0;
        rx_pin = loop_en ? m_v : rx_force;
    end

    task automatic do_reset();
        @(negedge serial_clock);
        reset = 1'b0;
        repeat (3) @(negedge serial_clock);
        reset = 1'b1;
    endtask

    task automatic wait_sent(input int n, input int budget, input string tag);
        int c = 0;
        while (bytes_sent < 16'(n) && c < budget) begin
            @(negedge serial_clock);
            c++;
        end
        if (bytes_sent < 16'(n)) check_eq(tag, bytes_sent, n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (busy && c < budget) begin
            @(negedge serial_clock);
            c++;
        end
        if (busy) check_eq(tag, busy, 0);
    endtask

    int cyc;
    int frames_before;

    initial begin
        // reset state
        do_reset();
        @(negedge serial_clock);
        check_eq("rst_tx_pin", tx_pin, 1);
        check_eq("rst_sent", bytes_sent, 0);
        check_eq("rst_matched", bytes_matched, 0);
        check_eq("rst_errors", error_count, 0);
        check_eq("rst_last_exp", last_expected, 0);
        check_eq("rst_last_rcv", last_received, 0);
        check_eq("rst_framing", framing_error, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_busy", busy, 0);

        // clean loopback, 300 frames, pattern wraps twice
        pat_chk = 1'b1;
        do_reset();
        enable = 1'b1;
        wait_sent(300, 60000, "loop_sent_timeout");
        enable = 1'b0;
        wait_idle(400, "loop_drain");
        check_eq("loop_sent", bytes_sent, 300);
        check_eq("loop_matched", bytes_matched, 300);
        check_eq("loop_errors", error_count, 0);
        check_eq("loop_framing", framing_error, 0);
        check_eq("loop_timeout", timeout, 0);
        check_eq("loop_wrap_zeros", m_zero, 3);
        pat_chk = 1'b0;

        // bit 3 flipped on the 5th echo
        flip_frame = 5;
        do_reset();
        enable = 1'b1;
        wait_sent(10, 3000, "flip_sent_timeout");
        enable = 1'b0;
        wait_idle(400, "flip_drain");
        check_eq("flip_sent", bytes_sent, 10);
        check_eq("flip_matched", bytes_matched, 9);
        check_eq("flip_errors", error_count, 1);
        check_eq("flip_last_exp", last_expected, 8'h04);
        check_eq("flip_last_rcv", last_received, 8'h0C);
        check_eq("flip_framing", framing_error, 0);
        flip_frame = 0;

        // stop bit driven low on the 3rd echo
        stop_low_frame = 3;
        do_reset();
        enable = 1'b1;
        wait_sent(6, 2000, "stop_sent_timeout");
        enable = 1'b0;
        wait_idle(400, "stop_drain");
        check_eq("stop_framing", framing_error, 1);
        check_eq("stop_errors", error_count, 1);
        check_eq("stop_matched", bytes_matched, 5);
        check_eq("stop_last_exp", last_expected, 8'h02);
        check_eq("stop_last_rcv", last_received, 8'h02);
        stop_low_frame = 0;

        // no echo at all: queue fills, then times out and flushes
        cpb = 12'd8;
        loop_en = 1'b0;
        rx_force = 1'b1;
        enable = 1'b1;
        do_reset();
        wait_sent(1, 100, "to_first_timeout");
        cyc = 0;
        while (!timeout && cyc < 2000) begin
            @(negedge serial_clock);
            cyc++;
        end
        check_eq("to_flag", timeout, 1);
        check_eq("to_cycles", cyc, 320);
        check_eq("to_sent", bytes_sent, 4);
        check_eq("to_errors", error_count, 1);
        check_eq("to_matched", bytes_matched, 0);
        wait_sent(5, 200, "to_resume");
        check_eq("to_resume_sent", bytes_sent, 5);
        enable = 1'b0;

        // cts held low for 1000 cycles mid-run
        cpb = 12'd16;
        loop_en = 1'b1;
        do_reset();
        enable = 1'b1;
        wait_sent(3, 2000, "cts_sent_timeout");
        repeat (20) @(negedge serial_clock);
        cts_pin = 1'b0;
        frames_before = m_frame;
        repeat (1000) @(negedge serial_clock);
        check_eq("cts_sent_hold", bytes_sent, 3);
        check_eq("cts_no_start", m_frame, frames_before);
        check_eq("cts_tx_idle", tx_pin, 1);
        check_eq("cts_busy", busy, 0);
        cts_pin = 1'b1;
        wait_sent(4, 100, "cts_resume");
        enable = 1'b0;
        wait_idle(400, "cts_drain");
        check_eq("cts_matched", bytes_matched, 4);
        check_eq("cts_errors", error_count, 0);

        // 3-cycle low glitch on the idle line
        loop_en = 1'b0;
        rx_force = 1'b1;
        repeat (5) @(negedge serial_clock);
        rx_force = 1'b0;
        repeat (3) @(negedge serial_clock);
        rx_force = 1'b1;
        repeat (400) @(negedge serial_clock);
        check_eq("glitch_errors", error_count, 0);
        check_eq("glitch_matched", bytes_matched, 4);
        check_eq("glitch_framing", framing_error, 0);
        check_eq("glitch_busy", busy, 0);

        // reset in the middle of a tx frame
        loop_en = 1'b1;
        enable = 1'b1;
        wait_sent(5, 300, "mid_sent_timeout");
        repeat (30) @(negedge serial_clock);
        reset = 1'b0;
        @(negedge serial_clock);
        check_eq("mid_rst_tx_pin", tx_pin, 1);
        check_eq("mid_rst_sent", bytes_sent, 0);
        check_eq("mid_rst_matched", bytes_matched, 0);
        check_eq("mid_rst_busy", busy, 0);
        enable = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge serial_clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
